// File: rtl/seg_pkg.sv
// Shared seven-segment glyph constants and the hex/decimal glyph table.
// Glyphs are active-low, bit 7 is the decimal point, bits 6..0 are g..a.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Glyph with the decimal point off; decimal mode turns A..F into a dash.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dec_mode);
    logic [7:0] g;
    case (nibble)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      default: g = 8'h8E;
    endcase
    if (dec_mode && nibble > 4'd9) g = SEG_DASH;
    return g;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble-to-segment decoder with decimal-point control.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dec_mode,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  assign glyph = hex_to_seg(nibble, dec_mode);
  assign seg   = {glyph[7] & ~dp, glyph[6:0]};

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scanner with shadowed value/masks,
// per-digit blink/blank/dp and leading-zero suppression.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 250000,
  parameter int BLINK_TICKS = 21
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  dec_mode,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PW-1:0]       pre_cnt;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       blink_cnt;
  logic                show;

  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_blink;
  logic [DIGITS-1:0]   sh_blank;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_dec;
  logic                sh_lz;

  logic                tick;
  logic                blink_wrap;
  logic                show_next;
  logic [IW-1:0]       idx_next;
  logic [3:0]          sel_nibble;
  logic [7:0]          glyph;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   an_next;
  logic [DIGITS-1:0]   lz_sup;

  assign tick       = (pre_cnt == PW'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BW'(BLINK_TICKS - 1));
  assign show_next  = blink_wrap ? ~show : show;
  assign idx_next   = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
  assign sel_nibble = sh_value[{idx_next, 2'b00} +: 4];
  assign an_next    = ~(DIGITS'(1) << idx_next);

  // A digit is suppressed when it and every more significant digit are zero.
  always_comb begin
    logic run;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch; blocking '=' is correct here.
    lz_sup = '0;
    run    = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run       = run & (sh_value[k*4 +: 4] == 4'h0);
      lz_sup[k] = sh_lz & run;
    end
  end

  seg_decoder u_dec (
    .nibble   (sel_nibble),
    .dec_mode (sh_dec),
    .dp       (sh_dp[idx_next]),
    .seg      (glyph)
  );

  // Content for the digit about to be driven; the blink phase is the one
  // that takes effect at this same tick edge.
  always_comb begin
    seg_next = glyph;
    if (sh_blank[idx_next])                    seg_next = SEG_BLANK;
    else if (sh_blink[idx_next] && !show_next) seg_next = SEG_BLANK;
    else if (lz_sup[idx_next])                 seg_next = SEG_BLANK;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pre_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      show      <= 1'b1;
      sh_value  <= '0;
      sh_blink  <= '0;
      sh_blank  <= '0;
      sh_dp     <= '0;
      sh_dec    <= 1'b0;
      sh_lz     <= 1'b0;
      seg       <= SEG_BLANK;
      an        <= '1;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (load) begin
        sh_value <= value;
        sh_blink <= blink_mask;
        sh_blank <= blank_mask;
        sh_dp    <= dp_mask;
        sh_dec   <= dec_mode;
        sh_lz    <= lz_en;
      end
      if (tick) begin
        idx       <= idx_next;
        blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
        show      <= show_next;
        seg       <= seg_next;
        an        <= an_next;
      end
    end
  end

endmodule
